// File: rtl/mul8_seq.sv
// Unsigned 8x8 sequential shift-add multiplier. All additions go through an
// external 8-bit adder; one partial-product bit is retired per CALC cycle.
module mul8_seq (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [7:0]  iData_a,
  input  logic [7:0]  iData_b,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oData,
  output logic [7:0]  oAdd_a,
  output logic [7:0]  oAdd_b,
  output logic        oAdd_c,
  input  logic [7:0]  iAdd_sum,
  input  logic        iAdd_co
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      stateQ, stateD;
  logic [7:0]  mQ, mD;
  logic [7:0]  hQ, hD;
  logic [7:0]  lQ, lD;
  logic [2:0]  cntQ, cntD;
  logic [15:0] dataQ, dataD;
  logic [15:0] shifted;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ <= IDLE;
      mQ     <= '0;
      hQ     <= '0;
      lQ     <= '0;
      cntQ   <= '0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      mQ     <= mD;
      hQ     <= hD;
      lQ     <= lD;
      cntQ   <= cntD;
      dataQ  <= dataD;
    end
  end

  // The adder carry-out becomes the new MSB of {H,L} as the pair shifts right.
  always_comb begin
    stateD  = stateQ;
    mD      = mQ;
    hD      = hQ;
    lD      = lQ;
    cntD    = cntQ;
    dataD   = dataQ;
    oAdd_a  = '0;
    oAdd_b  = '0;
    oAdd_c  = 1'b0;
    shifted = {iAdd_co, iAdd_sum, lQ[7:1]};
    case (stateQ)
      IDLE: begin
        if (iStart) begin
          mD     = iData_a;
          hD     = '0;
          lD     = iData_b;
          cntD   = '0;
          stateD = CALC;
        end
      end
      CALC: begin
        oAdd_a = hQ;
        oAdd_b = lQ[0] ? mQ : 8'h00;
        hD     = shifted[15:8];
        lD     = shifted[7:0];
        if (cntQ == 3'd7) begin
          dataD  = shifted;
          stateD = DONE;
        end else begin
          cntD = cntQ + 3'd1;
        end
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  assign oBusy = (stateQ == CALC);
  assign oDone = (stateQ == DONE);
  assign oData = dataQ;

endmodule

// File: tb/tb_mul8_seq.sv
// Bench for mul8_seq paired with a bit-level ripple adder; expected products
// are queued when a start is driven and popped when oDone is seen.
module tb_mul8_seq;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [7:0]  iData_a, iData_b;
  logic        oBusy, oDone;
  logic [15:0] oData;
  logic [7:0]  addA, addB, addSum;
  logic        addCi, addCo, rippleC;

  int nCompared = 0;
  int nMismatched = 0;
  logic [15:0] expQ[$];

  mul8_seq dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData),
    .oAdd_a  (addA),
    .oAdd_b  (addB),
    .oAdd_c  (addCi),
    .iAdd_sum(addSum),
    .iAdd_co (addCo)
  );

  always #5 iClk = ~iClk;

  // Ripple-carry adder standing in for the external adder block.
  always_comb begin
    rippleC = addCi;
    addSum  = '0;
    for (int i = 0; i < 8; i++) begin
      addSum[i] = addA[i] ^ addB[i] ^ rippleC;
      rippleC   = (addA[i] & addB[i]) | (rippleC & (addA[i] ^ addB[i]));
    end
    addCo = rippleC;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] popExp();
    if (expQ.size() == 0) return 16'hxxxx;
    return expQ.pop_front();
  endfunction

  // Starts one operation from IDLE and watches 24 cycles, recording observations.
  task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                       output int doneAt, output int busyCnt, output int doneCnt,
                       output bit sawCo, output bit addBNonZero, output bit dataMoved,
                       output logic [15:0] got);
    logic [15:0] prev;
    doneAt = 0; busyCnt = 0; doneCnt = 0;
    sawCo = 0; addBNonZero = 0; dataMoved = 0; got = 16'hxxxx;
    prev = oData;
    iStart = 1'b1; iData_a = a; iData_b = b;
    expQ.push_back(16'(a) * 16'(b));
    for (int n = 1; n <= 24; n++) begin
      @(negedge iClk);
      if (n == 1) begin
        iStart = 1'b0;
        iData_a = 8'($urandom);
        iData_b = 8'($urandom);
      end
      if (oBusy) begin
        busyCnt++;
        if (addCo) sawCo = 1;
        if (addB != 8'h00) addBNonZero = 1;
        if (oData !== prev) dataMoved = 1;
      end
      if (oDone) begin
        doneCnt++;
        if (doneAt == 0) begin
          doneAt = n;
          got = oData;
        end
      end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; iData_a = 8'h5A; iData_b = 8'hA5;
    repeat (2) @(negedge iClk);
    nCompared++;
    if ({oBusy, oDone} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b want 00", {oBusy, oDone});
    end
    nCompared++;
    if (oData !== 16'h0000) begin
      nMismatched++;
      $display("[TB] FAIL reset_data: got %h want 0000", oData);
    end
    nCompared++;
    if ({addA, addB, addCi} !== 17'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_adder: got %h want 00000", {addA, addB, addCi});
    end
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic test_basic();
    int doneAt, busyCnt, doneCnt;
    bit sawCo, addBNz, moved;
    logic [15:0] got, exp;
    runOp(8'h0F, 8'h11, doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
    exp = popExp();
    nCompared++;
    if (got !== exp || got !== 16'h00FF) begin
      nMismatched++;
      $display("[TB] FAIL basic_product: got %h want %h", got, exp);
    end
    nCompared++;
    if (doneAt !== 9) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got %0d want 9", doneAt);
    end
    nCompared++;
    if (busyCnt !== 8) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy_cycles: got %0d want 8", busyCnt);
    end
    nCompared++;
    if (doneCnt !== 1) begin
      nMismatched++;
      $display("[TB] FAIL basic_done_count: got %0d want 1", doneCnt);
    end
    nCompared++;
    if (moved !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_data_stable_in_calc: got %b want 0", moved);
    end
    nCompared++;
    if (oData !== 16'h00FF) begin
      nMismatched++;
      $display("[TB] FAIL basic_data_hold: got %h want 00ff", oData);
    end
  endtask

  task automatic test_max();
    int doneAt, busyCnt, doneCnt;
    bit sawCo, addBNz, moved;
    logic [15:0] got, exp;
    runOp(8'hFF, 8'hFF, doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
    exp = popExp();
    nCompared++;
    if (got !== exp || got !== 16'hFE01) begin
      nMismatched++;
      $display("[TB] FAIL max_product: got %h want %h", got, exp);
    end
    nCompared++;
    if (sawCo !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL max_carry_seen: got %b want 1", sawCo);
    end
  endtask

  task automatic test_zero();
    int doneAt, busyCnt, doneCnt;
    bit sawCo, addBNz, moved;
    logic [15:0] got, exp;
    runOp(8'h00, 8'h55, doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
    exp = popExp();
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL zero_a_product: got %h want %h", got, exp);
    end
    runOp(8'h55, 8'h00, doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
    exp = popExp();
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL zero_b_product: got %h want %h", got, exp);
    end
    nCompared++;
    if (addBNz !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL zero_b_addend: got %b want 0", addBNz);
    end
  endtask

  task automatic test_restart_ignored();
    int doneAt = 0, doneCnt = 0;
    bit busyLate = 0;
    logic [15:0] got = 16'hxxxx, exp;
    iStart = 1'b1; iData_a = 8'h12; iData_b = 8'h34;
    expQ.push_back(16'h0012 * 16'h0034);
    for (int n = 1; n <= 24; n++) begin
      @(negedge iClk);
      if (n == 1) iStart = 1'b0;
      if (n == 4) begin
        iStart = 1'b1; iData_a = 8'hAA; iData_b = 8'hBB;
      end
      if (n == 5) iStart = 1'b0;
      if (oBusy && n > 9) busyLate = 1;
      if (oDone) begin
        doneCnt++;
        if (doneAt == 0) begin
          doneAt = n;
          got = oData;
        end
      end
    end
    exp = popExp();
    nCompared++;
    if (got !== exp || got !== 16'h03A8) begin
      nMismatched++;
      $display("[TB] FAIL restart_product: got %h want %h", got, exp);
    end
    nCompared++;
    if (doneCnt !== 1 || doneAt !== 9) begin
      nMismatched++;
      $display("[TB] FAIL restart_single_done: got count %0d at %0d want 1 at 9", doneCnt, doneAt);
    end
    nCompared++;
    if (busyLate !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL restart_request_lost: got busy-after-done %b want 0", busyLate);
    end
  endtask

  task automatic test_reset_abort();
    int doneAt, busyCnt, doneCnt, lateDone = 0;
    bit sawCo, addBNz, moved, busyAtHit;
    logic [15:0] got, exp;
    iStart = 1'b1; iData_a = 8'h80; iData_b = 8'h80;
    for (int n = 1; n <= 5; n++) begin
      @(negedge iClk);
      if (n == 1) iStart = 1'b0;
    end
    busyAtHit = oBusy;
    iRst = 1'b1;
    #1;
    nCompared++;
    if (busyAtHit !== 1'b1 || {oBusy, oDone} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL abort_flags: got busy-before %b flags %b want 1/00", busyAtHit, {oBusy, oDone});
    end
    nCompared++;
    if (oData !== 16'h0000 || {addA, addB, addCi} !== 17'h0) begin
      nMismatched++;
      $display("[TB] FAIL abort_outputs: got data %h adder %h want 0000/00000", oData, {addA, addB, addCi});
    end
    @(negedge iClk);
    iRst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge iClk);
      if (oDone) lateDone++;
    end
    nCompared++;
    if (lateDone !== 0) begin
      nMismatched++;
      $display("[TB] FAIL abort_no_done: got %0d pulses want 0", lateDone);
    end
    runOp(8'h80, 8'h02, doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
    exp = popExp();
    nCompared++;
    if (got !== exp || got !== 16'h0100 || doneAt !== 9) begin
      nMismatched++;
      $display("[TB] FAIL abort_recover: got %h at %0d want %h at 9", got, doneAt, exp);
    end
  endtask

  task automatic test_back_to_back();
    int doneAt[2] = '{0, 0};
    int k = 0;
    logic [15:0] exp;
    iStart = 1'b1; iData_a = 8'd7; iData_b = 8'd9;
    expQ.push_back(16'd63);
    expQ.push_back(16'd600);
    for (int n = 1; n <= 30; n++) begin
      @(negedge iClk);
      if (n == 1) begin
        iData_a = 8'd200; iData_b = 8'd3;
      end
      if (oDone) begin
        exp = popExp();
        nCompared++;
        if (oData !== exp) begin
          nMismatched++;
          $display("[TB] FAIL b2b_product%0d: got %h want %h", k, oData, exp);
        end
        if (k < 2) doneAt[k] = n;
        k++;
        if (k == 2) iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    nCompared++;
    if (k !== 2 || doneAt[0] !== 9 || doneAt[1] !== 19) begin
      nMismatched++;
      $display("[TB] FAIL b2b_timing: got %0d dones at %0d,%0d want 2 at 9,19", k, doneAt[0], doneAt[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] aTab[6] = '{8'h01, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00};
    logic [7:0] bTab[6] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
    int doneAt, busyCnt, doneCnt;
    bit sawCo, addBNz, moved;
    logic [15:0] got, exp;
    for (int i = 3; i < 6; i++) begin
      aTab[i] = 8'($urandom);
      bTab[i] = 8'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      runOp(aTab[i], bTab[i], doneAt, busyCnt, doneCnt, sawCo, addBNz, moved, got);
      exp = popExp();
      nCompared++;
      if (got !== exp || doneAt !== 9) begin
        nMismatched++;
        $display("[TB] FAIL random_%0d %h*%h: got %h at %0d want %h at 9", i, aTab[i], bTab[i], got, doneAt, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
